// File: rtl/bcd_disp_pkg.sv
// Shared types and constants for the two-digit multiplexed 7-segment scanner.
package bcd_disp_pkg;

  typedef enum logic [1:0] {SHOW0, GAP0, SHOW1, GAP1} state_e;

  // Segment order {g,f,e,d,c,b,a}, active-high.
  localparam logic [6:0] SEG_0    = 7'h3F;
  localparam logic [6:0] SEG_1    = 7'h06;
  localparam logic [6:0] SEG_2    = 7'h5B;
  localparam logic [6:0] SEG_3    = 7'h4F;
  localparam logic [6:0] SEG_4    = 7'h66;
  localparam logic [6:0] SEG_5    = 7'h6D;
  localparam logic [6:0] SEG_6    = 7'h7D;
  localparam logic [6:0] SEG_7    = 7'h07;
  localparam logic [6:0] SEG_8    = 7'h7F;
  localparam logic [6:0] SEG_9    = 7'h6F;
  localparam logic [6:0] SEG_DASH = 7'h40;
  localparam logic [6:0] SEG_OFF  = 7'h00;

  localparam logic [1:0] AN_OFF = 2'b11;
  localparam logic [1:0] AN_D0  = 2'b10;
  localparam logic [1:0] AN_D1  = 2'b01;

endpackage

// File: rtl/bcd_to_7seg.sv
// Combinational BCD to 7-segment decoder; non-BCD codes 10-15 show a dash.
module bcd_to_7seg
  import bcd_disp_pkg::*;
(
  input  logic [3:0] bcd_i,
  output logic [6:0] seg_o
);

  always_comb begin
    seg_o = SEG_DASH;
    case (bcd_i)
      4'd0:    seg_o = SEG_0;
      4'd1:    seg_o = SEG_1;
      4'd2:    seg_o = SEG_2;
      4'd3:    seg_o = SEG_3;
      4'd4:    seg_o = SEG_4;
      4'd5:    seg_o = SEG_5;
      4'd6:    seg_o = SEG_6;
      4'd7:    seg_o = SEG_7;
      4'd8:    seg_o = SEG_8;
      4'd9:    seg_o = SEG_9;
      default: seg_o = SEG_DASH;
    endcase
  end

endmodule

// File: rtl/bcd_display_scan.sv
// Two-digit multiplexed 7-segment scanner with per-frame snapshot, dead-time gaps and
// sticky overflow on the tens decimal point. Optional macro BCD_LZ_BLANK_EN blanks a zero tens digit.
module bcd_display_scan
  import bcd_disp_pkg::*;
#(
  parameter int unsigned SCAN_DIV = 50000
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic [3:0] Q0,
  input  logic [3:0] Q1,
  input  logic       tc,
  input  logic       clr,
  output logic [6:0] seg,
  output logic [1:0] an,
  output logic       dp,
  output logic       frame
);

  localparam int unsigned PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [PW-1:0] PMAX = PW'(SCAN_DIV - 1);

  logic [PW-1:0] presc_q;
  state_e        state_q, state_d;
  logic [3:0]    s0_q, s0_d, s1_q, s1_d;
  logic          ovf_q, ovf_d;
  logic          tick, snap;
  logic [3:0]    digit;
  logic [6:0]    dec_seg;
  logic [6:0]    seg_d;
  logic [1:0]    an_d;
  logic          dp_d;

  assign tick = (presc_q == PMAX);
  assign snap = tick && (state_q == GAP1);

  always_comb begin
    state_d = state_q;
    if (tick) begin
      unique case (state_q)
        SHOW0:   state_d = GAP0;
        GAP0:    state_d = SHOW1;
        SHOW1:   state_d = GAP1;
        default: state_d = SHOW0;
      endcase
    end
  end

  // Snapshot values are forwarded so SHOW0 shows the new digit on the very edge it is taken.
  assign s0_d  = snap ? Q0 : s0_q;
  assign s1_d  = snap ? Q1 : s1_q;
  assign ovf_d = tc ? 1'b1 : (clr ? 1'b0 : ovf_q);
  assign digit = (state_d == SHOW1) ? s1_d : s0_d;

  bcd_to_7seg u_dec (
    .bcd_i (digit),
    .seg_o (dec_seg)
  );

  always_comb begin
    seg_d = SEG_OFF;
    an_d  = AN_OFF;
    dp_d  = 1'b0;
    unique case (state_d)
      SHOW0: begin
        seg_d = dec_seg;
        an_d  = AN_D0;
      end
      SHOW1: begin
`ifdef BCD_LZ_BLANK_EN
        seg_d = (s1_d == 4'd0) ? SEG_OFF : dec_seg;
`else
        seg_d = dec_seg;
`endif
        an_d  = AN_D1;
        dp_d  = ovf_q;
      end
      default: begin
        seg_d = SEG_OFF;
        an_d  = AN_OFF;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      presc_q <= '0;
      state_q <= GAP1;
      s0_q    <= 4'd0;
      s1_q    <= 4'd0;
      ovf_q   <= 1'b0;
      seg     <= SEG_OFF;
      an      <= AN_OFF;
      dp      <= 1'b0;
      frame   <= 1'b0;
    end else begin
      presc_q <= tick ? '0 : presc_q + 1'b1;
      state_q <= state_d;
      s0_q    <= s0_d;
      s1_q    <= s1_d;
      ovf_q   <= ovf_d;
      seg     <= seg_d;
      an      <= an_d;
      dp      <= dp_d;
      frame   <= snap;
    end
  end

endmodule

// File: tb/tb_bcd_display_scan.sv
// Directed slot-by-slot bench for bcd_display_scan with SCAN_DIV=4.
module tb_bcd_display_scan;

  localparam int unsigned DIV = 4;

  logic       clk = 1'b0;
  logic       rstn;
  logic [3:0] Q0, Q1;
  logic       tc, clr;
  logic [6:0] seg;
  logic [1:0] an;
  logic       dp, frame;

  int n_total = 0;
  int n_pass  = 0;

  bcd_display_scan #(.SCAN_DIV(DIV)) dut (
    .clk   (clk),
    .rstn  (rstn),
    .Q0    (Q0),
    .Q1    (Q1),
    .tc    (tc),
    .clr   (clr),
    .seg   (seg),
    .an    (an),
    .dp    (dp),
    .frame (frame)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] q0;
    logic [3:0] q1;
    logic       tc;
    logic       clr;
    logic [6:0] seg;
    logic [1:0] an;
    logic       dp;
    logic       frame;
  } vec_t;

  vec_t tbl[19];

`ifdef BCD_LZ_BLANK_EN
  localparam logic [6:0] LZ_SEG = 7'h00;
`else
  localparam logic [6:0] LZ_SEG = 7'h3F;
`endif

  function automatic vec_t mk(input logic [3:0] q0, input logic [3:0] q1, input logic t,
                              input logic c, input logic [6:0] s, input logic [1:0] a,
                              input logic d, input logic f);
    vec_t v;
    v.q0 = q0; v.q1 = q1; v.tc = t; v.clr = c;
    v.seg = s; v.an = a; v.dp = d; v.frame = f;
    return v;
  endfunction

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %02h expected %02h at %0t", name, act, exp, $time);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all(input string tag, input logic [6:0] s, input logic [1:0] a,
                         input logic d, input logic f);
    chk({tag, ".seg"}, {1'b0, seg}, {1'b0, s});
    chk({tag, ".an"}, {6'd0, an}, {6'd0, a});
    chk({tag, ".dp"}, {7'd0, dp}, {7'd0, d});
    chk({tag, ".frame"}, {7'd0, frame}, {7'd0, f});
  endtask

  initial begin
    // One entry per scan slot; inputs applied just before the slot's first edge.
    tbl[0]  = mk(4'd3,  4'd7,  0, 0, 7'h4F, 2'b10, 0, 1);
    tbl[1]  = mk(4'd5,  4'd7,  0, 0, 7'h00, 2'b11, 0, 0);
    tbl[2]  = mk(4'd5,  4'd7,  0, 0, 7'h07, 2'b01, 0, 0);
    tbl[3]  = mk(4'd5,  4'd12, 0, 0, 7'h00, 2'b11, 0, 0);
    tbl[4]  = mk(4'd5,  4'd12, 0, 0, 7'h6D, 2'b10, 0, 1);
    tbl[5]  = mk(4'd5,  4'd12, 0, 0, 7'h00, 2'b11, 0, 0);
    tbl[6]  = mk(4'd5,  4'd12, 0, 0, 7'h40, 2'b01, 0, 0);
    tbl[7]  = mk(4'd15, 4'd9,  0, 0, 7'h00, 2'b11, 0, 0);
    tbl[8]  = mk(4'd15, 4'd9,  1, 0, 7'h40, 2'b10, 0, 1);
    tbl[9]  = mk(4'd15, 4'd9,  0, 0, 7'h00, 2'b11, 0, 0);
    tbl[10] = mk(4'd15, 4'd9,  0, 0, 7'h6F, 2'b01, 1, 0);
    tbl[11] = mk(4'd15, 4'd0,  1, 1, 7'h00, 2'b11, 0, 0);
    tbl[12] = mk(4'd0,  4'd0,  0, 0, 7'h3F, 2'b10, 0, 1);
    tbl[13] = mk(4'd0,  4'd0,  0, 0, 7'h00, 2'b11, 0, 0);
    tbl[14] = mk(4'd0,  4'd0,  0, 0, LZ_SEG, 2'b01, 1, 0);
    tbl[15] = mk(4'd9,  4'd1,  0, 1, 7'h00, 2'b11, 0, 0);
    tbl[16] = mk(4'd9,  4'd1,  0, 0, 7'h6F, 2'b10, 0, 1);
    tbl[17] = mk(4'd9,  4'd1,  0, 0, 7'h00, 2'b11, 0, 0);
    tbl[18] = mk(4'd9,  4'd1,  0, 0, 7'h06, 2'b01, 0, 0);

    rstn = 1'b0; Q0 = 4'd0; Q1 = 4'd0; tc = 1'b0; clr = 1'b0;
    #12;
    chk_all("reset", 7'h00, 2'b11, 0, 0);
    rstn = 1'b1;

    // Remainder of the GAP1 slot left by reset.
    for (int i = 0; i < 3; i++) begin
      step();
      chk_all("gap1_after_reset", 7'h00, 2'b11, 0, 0);
    end

    for (int v = 0; v < 19; v++) begin
      for (int k = 0; k < int'(DIV); k++) begin
        if (k == 0) begin
          Q0 = tbl[v].q0; Q1 = tbl[v].q1; tc = tbl[v].tc; clr = tbl[v].clr;
        end
        step();
        tc = 1'b0; clr = 1'b0;
        chk_all($sformatf("slot%0d_c%0d", v, k), tbl[v].seg, tbl[v].an, tbl[v].dp,
                (k == 0) ? tbl[v].frame : 1'b0);
      end
    end

    // tc sampled mid-SHOW1 reaches dp only on the following edge.
    for (int i = 0; i < 3 * int'(DIV); i++) step();
    step();
    chk("tc_latency.an", {6'd0, an}, 8'h01);
    chk("tc_latency.dp0", {7'd0, dp}, 8'h00);
    tc = 1'b1;
    step();
    tc = 1'b0;
    chk("tc_latency.dp_same_edge", {7'd0, dp}, 8'h00);
    step();
    chk("tc_latency.dp_next_edge", {7'd0, dp}, 8'h01);

    // Asynchronous reset mid-frame.
    #2;
    rstn = 1'b0;
    #1;
    chk_all("midframe_reset", 7'h00, 2'b11, 0, 0);
    #3;
    rstn = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk_all("post_reset_gap", 7'h00, 2'b11, 0, 0);
    end
    step();
    chk_all("post_reset_first_frame", 7'h6F, 2'b10, 0, 1);
    step();
    chk_all("post_reset_frame_drop", 7'h6F, 2'b10, 0, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
